// File: rtl/hazard_pkg.sv
// Shared types and defaults for the register-hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_REG_ADDR_W = 3;
    localparam int DEF_PIPE_DEPTH = 3;
    localparam int DEF_CNT_W      = $clog2(DEF_PIPE_DEPTH + 1);

    typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_CNT_W-1:0]      cnt_t;

    // Forwarding source seen by a consumer, counted in stages behind ID.
    typedef enum logic [DEF_CNT_W-1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_t;

    // Counter width able to hold values 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One pending-write countdown for a single architectural register.
// Latency: count loads on the edge after set, then drops by one per cycle to zero.
// Backpressure: none; set always wins over the decrement and re-arms the entry.
//
// Ports: clk, rst (sync, active-high), set (arm pulse), depth (value loaded on arm),
//        pending (count != 0), count (cycles left until writeback completes).
//        With HAZARD_FWD_EN: set_load (producer is a load), is_load (stored flag).
module sb_entry #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
`ifdef HAZARD_FWD_EN
    input  logic          set_load,
    output logic          is_load,
`endif
    input  logic [CW-1:0] depth,
    output logic          pending,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] ONE = CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (set) begin
            count <= depth;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

`ifdef HAZARD_FWD_EN
    // Flag is only meaningful while pending, so it is simply overwritten on each arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load <= 1'b0;
        end else if (set) begin
            is_load <= set_load;
        end
    end
`endif

    assign pending = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard driving the ID-stage RAW stall.
// Latency: stall is combinational from ID inputs; sb_busy/stall_cycles are registered.
// Backpressure: pipeline_stall_n=0 freezes IF/ID and bubbles EX; a stalled or flushed ID never arms.
//
// Ports: clk, rst (sync, active-high); id_valid, id_src1/2, id_src1/2_en, id_dest, id_wr_en,
//        id_flush describe the ID instruction; pipeline_stall_n (active-low stall),
//        sb_busy (any register pending), stall_cycles (saturating stalled-cycle count).
// Build option HAZARD_FWD_EN: adds id_is_load, fwd_src1_sel, fwd_src2_sel; only a load
//        in its first cycle after issue stalls a consumer, everything else is forwarded.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
    parameter int STALL_CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [REG_ADDR_W-1:0]             id_src1,
    input  logic [REG_ADDR_W-1:0]             id_src2,
    input  logic                              id_src1_en,
    input  logic                              id_src2_en,
    input  logic [REG_ADDR_W-1:0]             id_dest,
    input  logic                              id_wr_en,
    input  logic                              id_flush,
`ifdef HAZARD_FWD_EN
    input  logic                              id_is_load,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_src1_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_src2_sel,
`endif
    output logic                              pipeline_stall_n,
    output logic                              sb_busy,
    output logic [STALL_CNT_W-1:0]            stall_cycles
);

    localparam int            CW    = cnt_width(PIPE_DEPTH);
    localparam logic [CW-1:0] DEPTH = CW'(PIPE_DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    // Register 0 is hardwired zero, so only 1..NUM_REGS-1 get an entry.
    logic [CW-1:0]       cnt      [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] pend_vec;
    logic [NUM_REGS-1:1] set_vec;
`ifdef HAZARD_FWD_EN
    logic [NUM_REGS-1:1] load_vec;
`endif

    logic [CW-1:0] src1_cnt, src2_cnt;
    logic          src1_pend, src2_pend;
    logic          src1_load, src2_load;
    logic          haz1, haz2;
    logic          issue;
    logic          busy_nxt;

    // Pre-update counter lookup: an issuing instruction never sees its own arm,
    // so src==dest does not self-stall.
    always_comb begin
        src1_cnt  = '0;
        src2_cnt  = '0;
        src1_pend = 1'b0;
        src2_pend = 1'b0;
        src1_load = 1'b0;
        src2_load = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_src1 == REG_ADDR_W'(r)) begin
                src1_cnt  = cnt[r];
                src1_pend = pend_vec[r];
`ifdef HAZARD_FWD_EN
                src1_load = load_vec[r];
`endif
            end
            if (id_src2 == REG_ADDR_W'(r)) begin
                src2_cnt  = cnt[r];
                src2_pend = pend_vec[r];
`ifdef HAZARD_FWD_EN
                src2_load = load_vec[r];
`endif
            end
        end
    end

`ifdef HAZARD_FWD_EN
    // Only a load still in EX (count == depth) cannot be forwarded yet.
    assign haz1 = id_src1_en && (id_src1 != '0) && src1_pend && src1_load && (src1_cnt == DEPTH);
    assign haz2 = id_src2_en && (id_src2 != '0) && src2_pend && src2_load && (src2_cnt == DEPTH);
`else
    assign haz1 = id_src1_en && (id_src1 != '0) && src1_pend;
    assign haz2 = id_src2_en && (id_src2 != '0) && src2_pend;
    // Without forwarding the count value and load flags play no role in the stall.
    logic unused_src;
    assign unused_src = ^{src1_cnt, src2_cnt, src1_load, src2_load};
`endif

    assign pipeline_stall_n = !(id_valid && !id_flush && (haz1 || haz2));

    assign issue = id_valid && pipeline_stall_n && !id_flush && id_wr_en && (id_dest != '0);

`ifdef HAZARD_FWD_EN
    // depth+1-count gives the stage holding the producer: 1=EX, 2=MEM, 3=WB.
    assign fwd_src1_sel = (src1_pend && pipeline_stall_n) ? (DEPTH - src1_cnt + ONE) : '0;
    assign fwd_src2_sel = (src2_pend && pipeline_stall_n) ? (DEPTH - src2_cnt + ONE) : '0;
`endif

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        assign set_vec[r] = issue && (id_dest == REG_ADDR_W'(r));

        sb_entry #(.CW(CW)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (set_vec[r]),
`ifdef HAZARD_FWD_EN
            .set_load(id_is_load),
            .is_load (load_vec[r]),
`endif
            .depth   (DEPTH),
            .pending (pend_vec[r]),
            .count   (cnt[r])
        );
    end

    // Busy reflects the counters as they will be after this edge.
    always_comb begin
        busy_nxt = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_nxt = busy_nxt | set_vec[r] | (cnt[r] > ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            sb_busy <= busy_nxt;
            if (!pipeline_stall_n && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

endmodule
